// File: rtl/fs_mult_pkg.sv
// Shared types and sizing helpers for the sequential Ferrari-Stefanelli multiplier.
package fs_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DIGIT_W = 2;

  // Digit counter width: enough to index WIDTH/2 digits, never zero bits wide.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fs_digit_mult.sv
// Combinational multiplicand x 2-bit digit product, the 2x2 Ferrari-Stefanelli cell
// generalised across the multiplicand as a shift/add of a and 2a.
module fs_digit_mult
  import fs_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [DIGIT_W-1:0] d,
  output logic [WIDTH+1:0]   pp
);

  logic [WIDTH+1:0] a_1x;
  logic [WIDTH+1:0] a_2x;

  always_comb begin
    a_1x = d[0] ? {2'b00, a} : '0;
    a_2x = d[1] ? {1'b0, a, 1'b0} : '0;
    pp   = a_1x + a_2x;
  end

endmodule

// File: rtl/fs_seq_multiplier.sv
// Sequential unsigned multiplier retiring one 2-bit multiplier digit per clock, with
// start/busy/done handshake, optional accumulate and sticky overflow.
module fs_seq_multiplier
  import fs_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH / 2 - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              acc_q;

  logic [DIGIT_W-1:0] digit;
  logic [WIDTH+1:0]   pp;
  logic [PW-1:0]      pp_shift;
  logic [PW:0]        sum;

  fs_digit_mult #(
    .WIDTH (WIDTH)
  ) u_digit_mult (
    .a  (a_q),
    .d  (digit),
    .pp (pp)
  );

  // Digit n sits at bit 2n of b; its partial product is weighted by 4^n.
  always_comb begin
    digit    = DIGIT_W'(b_q >> {cnt_q, 1'b0});
    pp_shift = PW'(pp) << {cnt_q, 1'b0};
    sum      = {1'b0, product} + {1'b0, pp_shift};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= acc_en;
            cnt_q   <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state_q <= StRun;
            if (!acc_en) begin
              product <= '0;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          product <= sum[PW-1:0];
          // Without accumulate a*b always fits, so only an accumulating op can overflow.
          if (sum[PW] && acc_q) begin
            ovf <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs_seq_multiplier.sv
// Directed self-checking bench for fs_seq_multiplier at WIDTH=8.
module tb_fs_seq_multiplier;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               acc_en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               ovf;

  int total = 0;
  int bad   = 0;
  int cyc;
  int nbusy;
  int ndone;

  always #5 clk = ~clk;

  fs_seq_multiplier #(
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .acc_en  (acc_en),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a start for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic acc);
    @(negedge clk);
    a      = ai;
    b      = bi;
    acc_en = acc;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    acc_en = 1'b0;
    a      = 8'hA5;
    b      = 8'h5A;
  endtask

  // Bounded wait for done; counts cycles and busy samples on the way.
  task automatic wait_done(output int c, output int nb);
    c  = 0;
    nb = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
      if (busy) nb++;
    end while (!done && c < 20);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ai,
                        input logic [WIDTH-1:0] bi, input logic acc);
    issue(ai, bi, acc);
    check({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    wait_done(cyc, nbusy);
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_busy_cycles"}, 32'(nbusy + 1), 32'd4);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    acc_en = 1'b0;
    a      = '0;
    b      = '0;
    #2;
    check("rst_product", 32'(product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_product", 32'(product), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_ovf", 32'(ovf), 32'd0);

    run_op("m15x13", 8'd15, 8'd13, 1'b0);
    check("m15x13_product", 32'(product), 32'd195);
    check("m15x13_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_hold_product", 32'(product), 32'd195);

    run_op("m255x255", 8'd255, 8'd255, 1'b0);
    check("m255x255_product", 32'(product), 32'd65025);
    check("m255x255_ovf", 32'(ovf), 32'd0);

    run_op("m0x200", 8'd0, 8'd200, 1'b0);
    check("m0x200_product", 32'(product), 32'd0);

    run_op("acc_base", 8'd10, 8'd10, 1'b0);
    check("acc_base_product", 32'(product), 32'd100);
    run_op("acc_add", 8'd20, 8'd5, 1'b1);
    check("acc_add_product", 32'(product), 32'd200);
    check("acc_add_ovf", 32'(ovf), 32'd0);

    run_op("ovf_base", 8'd255, 8'd255, 1'b0);
    check("ovf_base_product", 32'(product), 32'd65025);
    run_op("ovf_acc", 8'd255, 8'd255, 1'b1);
    check("ovf_acc_product", 32'(product), 32'd64514);
    check("ovf_acc_ovf", 32'(ovf), 32'd1);
    issue(8'd3, 8'd3, 1'b0);
    check("ovf_clear_at_start", 32'(ovf), 32'd0);
    wait_done(cyc, nbusy);
    check("m3x3_product", 32'(product), 32'd9);

    // Start pulsed mid-RUN must not disturb the operation in flight.
    issue(8'd15, 8'd13, 1'b0);
    @(negedge clk);
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, nbusy);
    check("ignored_latency", 32'(cyc), 32'd3);
    check("ignored_product", 32'(product), 32'd195);

    // Start presented during DONE: accepted back-to-back, next done 5 cycles later.
    issue(8'd7, 8'd9, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(cyc, nbusy);
    check("b2b_interval", 32'(cyc + 1), 32'd5);
    check("b2b_product", 32'(product), 32'd63);

    // Reset in the second RUN cycle.
    issue(8'd15, 8'd13, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    run_op("m7x9", 8'd7, 8'd9, 1'b0);
    check("m7x9_product", 32'(product), 32'd63);
    check("m7x9_ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
